cb_config_master: RTL and testbench

Configuration initiator that drives the `config_addr` / `config_data` / `config_en` / `read_data` interface into a connect box or other configurable tile. It accepts a stream of configuration commands over a valid/ready handshake and issues single-cycle register writes. Each command can optionally be followed by a readback compare, or can be a pure read. Mismatches are counted and reported, so a bitstream load can be verified in place.

---
 rtl/cb_config_master_if.sv | 53 +++++
 rtl/cb_config_master.sv | 140 ++++++++++++++
 tb/tb_cb_config_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_config_master_if.sv
// -----------------------------------------------------------------------------
// cb_config_master_if
//   Bundles the command handshake, the configuration bus into the target tile
//   and the readback/status outputs of cb_config_master.
//
//   master modport : the cb_config_master side (drives config_*, rsp_*, status)
//   slave  modport : the environment side (drives cmd_*, returns read_data)
//
//   Signals
//     cmd_valid/cmd_ready        command handshake
//     cmd_op[1:0]                00 write, 01 write+verify, 10 read, 11 no-op
//     cmd_addr/cmd_data          target address, write / expected data
//     config_addr/config_data    registered address and data to the target
//     config_en                  single-cycle write strobe to the target
//     read_data                  readback from the target
//     rsp_valid/rsp_data         one-cycle readback result pulse + held data
//     mismatch                   one-cycle verify-failure pulse
//     err_addr/err_count         last failing address, saturating fail count
//     busy                       command in flight
// -----------------------------------------------------------------------------
interface cb_config_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ERR_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [ADDR_WIDTH-1:0] config_addr;
  logic [DATA_WIDTH-1:0] config_data;
  logic                  config_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  mismatch;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic [ERR_WIDTH-1:0]  err_count;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, read_data,
    output cmd_ready, config_addr, config_data, config_en,
           rsp_valid, rsp_data, mismatch, err_addr, err_count, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, read_data,
    input  cmd_ready, config_addr, config_data, config_en,
           rsp_valid, rsp_data, mismatch, err_addr, err_count, busy
  );
endinterface

// File: rtl/cb_config_master.sv
// -----------------------------------------------------------------------------
// cb_config_master
//   Configuration initiator for a connect box / configurable tile. Accepts
//   commands over a valid/ready handshake, issues single-cycle register
//   writes, and optionally reads the register back and compares it against
//   the written value, counting mismatches so a bitstream load can be
//   verified in place.
//
//   Ports
//     clk    : single clock
//     reset  : synchronous, active-low reset
//     bus    : cb_config_master_if.master (command, config bus, status)
//
//   Every output is a flop. The next-cycle value of each control output is
//   derived from the next FSM state, so there is no input-to-output
//   combinational path.
//
//   READ_LATENCY counts the cycles config_addr is held stable (config_en low)
//   before read_data is sampled; sampling happens at the edge ending the last
//   WAIT cycle.
// -----------------------------------------------------------------------------
module cb_config_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  cb_config_master_if.master    bus
);

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_VERIFY = 2'b01,
    OP_READ   = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT,
    CHECK
  } state_e;

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             capture;
  logic             verify_fail;

  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        // cmd_ready is itself a flop, so it also gates the first cycle after
        // reset release when state is already IDLE.
        if (bus.cmd_valid && bus.cmd_ready) begin
          accept = 1'b1;
          case (op_e'(bus.cmd_op))
            OP_WRITE, OP_VERIFY: state_d = WRITE;
            OP_READ:             state_d = WAIT;
            default:             state_d = IDLE;
          endcase
        end
      end
      WRITE:   state_d = (op_q == OP_VERIFY) ? WAIT : IDLE;
      WAIT:    if (cnt_q == '0) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readback is taken on the edge that ends the last WAIT cycle.
  assign capture     = (state_q == WAIT) && (cnt_q == '0);
  assign verify_fail = capture && (op_q == OP_VERIFY) &&
                       (bus.read_data != bus.config_data);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is only seen at a rising edge, which is
    // why it lives inside the clocked branch rather than the sensitivity list.
    if (!reset) begin
      state_q         <= IDLE;
      op_q            <= OP_WRITE;
      cnt_q           <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.config_en   <= 1'b0;
      bus.config_addr <= '0;
      bus.config_data <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.mismatch    <= 1'b0;
      bus.err_addr    <= '0;
      bus.err_count   <= '0;
    end else begin
      state_q       <= state_d;
      bus.cmd_ready <= (state_d == IDLE);
      bus.busy      <= (state_d != IDLE);
      bus.config_en <= (state_d == WRITE);
      bus.rsp_valid <= capture;
      bus.mismatch  <= verify_fail;

      // A no-op is consumed without touching the bus registers.
      if (accept && (op_e'(bus.cmd_op) != OP_NOP)) begin
        op_q            <= op_e'(bus.cmd_op);
        bus.config_addr <= bus.cmd_addr;
        bus.config_data <= bus.cmd_data;
      end

      // Load on WAIT entry, count down while in WAIT; zero marks the last cycle.
      if ((state_d == WAIT) && (state_q != WAIT)) begin
        cnt_q <= CNT_W'(READ_LATENCY - 1);
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (capture) begin
        bus.rsp_data <= bus.read_data;
      end

      if (verify_fail) begin
        bus.err_addr <= bus.config_addr;
        if (bus.err_count != '1) begin
          bus.err_count <= bus.err_count + ERR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cb_config_master.sv
// -----------------------------------------------------------------------------
// tb_cb_config_master
//   Scoreboard bench for cb_config_master. The stimulus pushes expected
//   target writes and expected readback responses (data, mismatch flag,
//   error address/count, cycle of arrival) into queues; a monitor on the
//   falling edge pops and compares whenever config_en or rsp_valid is seen.
//   The behavioural target writes on clk when config_en is high and returns
//   the addressed register combinationally, i.e. valid within the first cycle
//   config_addr is stable (READ_LATENCY = 1).
// -----------------------------------------------------------------------------
module tb_cb_config_master;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int EW = 8;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cb_config_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW)) bus ();

  cb_config_master #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .ERR_WIDTH   (EW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  // ---------------- behavioural target ----------------
  logic [DW-1:0] mem [0:255] = '{default: '0};
  logic          force_zero = 1'b0;
  logic          poke_en    = 1'b0;
  logic [AW-1:0] poke_addr  = '0;
  logic [DW-1:0] poke_data  = '0;

  always @(posedge clk) begin
    if (poke_en)       mem[poke_addr]       <= poke_data;
    if (bus.config_en) mem[bus.config_addr] <= bus.config_data;
  end
  assign bus.read_data = force_zero ? '0 : mem[bus.config_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          mm;
    logic [AW-1:0] eaddr;
    logic [EW-1:0] ecnt;
    int            cyc;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t r_exp;
  wr_t  w_exp;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [EW-1:0] m_cnt   = '0;
  logic [AW-1:0] m_eaddr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every observed write strobe and response pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.config_en) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                   bus.config_addr, bus.config_data, cyc);
        end else begin
          w_exp = wr_q.pop_front();
          check("wr_addr",  bus.config_addr, w_exp.addr);
          check("wr_data",  bus.config_data, w_exp.data);
          check("wr_cycle", cyc,             w_exp.cyc);
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_data %0h, expected no response (cycle %0d)",
                   bus.rsp_data, cyc);
        end else begin
          r_exp = rsp_q.pop_front();
          check("rsp_data",  bus.rsp_data,  r_exp.data);
          check("mismatch",  bus.mismatch,  r_exp.mm);
          check("err_addr",  bus.err_addr,  r_exp.eaddr);
          check("err_count", bus.err_count, r_exp.ecnt);
          check("rsp_cycle", cyc,           r_exp.cyc);
        end
      end else if (bus.mismatch) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_mismatch: got mismatch 1 without rsp_valid, expected 0 (cycle %0d)", cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called and returns on a falling edge.
  task automatic wait_ready();
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("ready_timeout", bus.cmd_ready, 1'b1);
  endtask

  // Issues one command, pushing its expected write and response. exp_rd is
  // the value the target is expected to return for verify/read. Returns on
  // the falling edge of the cycle after acceptance; acc is the accept cycle.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [DW-1:0] exp_rd,
                      output int acc);
    logic mm;
    wait_ready();
    acc = cyc;
    if (op == 2'b00 || op == 2'b01) wr_q.push_back('{addr: addr, data: data, cyc: acc + 1});
    if (op == 2'b01) begin
      mm = (exp_rd != data);
      if (mm) begin
        m_eaddr = addr;
        if (m_cnt != '1) m_cnt++;
      end
      rsp_q.push_back('{data: exp_rd, mm: mm, eaddr: m_eaddr, ecnt: m_cnt, cyc: acc + 2 + RL});
    end
    if (op == 2'b10) begin
      rsp_q.push_back('{data: exp_rd, mm: 1'b0, eaddr: m_eaddr, ecnt: m_cnt, cyc: acc + 1 + RL});
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    // While the block is busy, present a bogus write that must be ignored.
    if (op != 2'b11) begin
      bus.cmd_op   = 2'b00;
      bus.cmd_addr = '1;
      bus.cmd_data = '1;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int acc1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;

    // Reset values: reset low for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_config_en",   bus.config_en,   1'b0);
    check("rst_config_addr", bus.config_addr, 0);
    check("rst_config_data", bus.config_data, 0);
    check("rst_cmd_ready",   bus.cmd_ready,   1'b0);
    check("rst_rsp_valid",   bus.rsp_valid,   1'b0);
    check("rst_rsp_data",    bus.rsp_data,    0);
    check("rst_mismatch",    bus.mismatch,    1'b0);
    check("rst_err_addr",    bus.err_addr,    0);
    check("rst_err_count",   bus.err_count,   0);
    check("rst_busy",        bus.busy,        1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", bus.cmd_ready, 1'b1);
    check("rel_busy",      bus.busy,      1'b0);

    // Plain write: one strobe, cmd_ready low for exactly one cycle.
    send(2'b00, 8'h00, 16'h0006, 16'h0000, acc);
    check("wr_ready_low", bus.cmd_ready, 1'b0);
    check("wr_busy",      bus.busy,      1'b1);
    @(negedge clk);
    check("wr_ready_back", bus.cmd_ready, 1'b1);
    check("wr_reg0",       mem[0],        16'h0006);

    // Verify, pass.
    send(2'b01, 8'h00, 16'h0070, 16'h0070, acc);
    wait_ready();
    check("vp_err_count", bus.err_count, 0);
    check("vp_reg0",      mem[0],        16'h0070);

    // Read op of a preloaded register.
    poke_en   = 1'b1;
    poke_addr = 8'h03;
    poke_data = 16'hABCD;
    @(negedge clk);
    poke_en = 1'b0;
    send(2'b10, 8'h03, 16'h1234, 16'hABCD, acc);
    wait_ready();
    check("rd_rsp_hold", bus.rsp_data, 16'hABCD);

    // No-op: consumed at once, bus registers untouched, next command in N+1.
    send(2'b11, 8'h44, 16'h9999, 16'h0000, acc1);
    check("nop_ready",       bus.cmd_ready,   1'b1);
    check("nop_busy",        bus.busy,        1'b0);
    check("nop_config_addr", bus.config_addr, 8'h03);
    check("nop_config_data", bus.config_data, 16'h1234);
    send(2'b00, 8'h20, 16'h0077, 16'h0000, acc);
    check("nop_next_accept", acc, acc1 + 1);

    // Verify, fail, then saturate the counter.
    force_zero = 1'b1;
    send(2'b01, 8'h05, 16'h0001, 16'h0000, acc);
    wait_ready();
    check("vf_err_addr",  bus.err_addr,  8'h05);
    check("vf_err_count", bus.err_count, 8'd1);
    for (int i = 0; i < 300; i++) begin
      send(2'b01, 8'h05, 16'h0001, 16'h0000, acc);
    end
    wait_ready();
    check("sat_err_count", bus.err_count, 8'd255);
    check("sat_err_addr",  bus.err_addr,  8'h05);
    force_zero = 1'b0;

    // Mid-operation reset during WAIT of a verify.
    send(2'b01, 8'h09, 16'h0055, 16'h0055, acc);
    @(negedge clk);
    check("mr_in_wait", bus.busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    void'(rsp_q.pop_back());
    m_cnt   = '0;
    m_eaddr = '0;
    check("mr_config_en", bus.config_en, 1'b0);
    check("mr_rsp_valid", bus.rsp_valid, 1'b0);
    check("mr_mismatch",  bus.mismatch,  1'b0);
    check("mr_err_count", bus.err_count, 0);
    check("mr_busy",      bus.busy,      1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mr_ready_back", bus.cmd_ready, 1'b1);
    send(2'b01, 8'h09, 16'h0055, 16'h0055, acc);
    wait_ready();
    repeat (4) @(negedge clk);
    check("end_err_count", bus.err_count, 0);
    check("end_rsp_q_empty", rsp_q.size(), 0);
    check("end_wr_q_empty",  wr_q.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
